regfile_wb_arbiter: RTL and testbench

//  Shares the single register-file write port between two writeback sources:
//  ALU (single-cycle results) and LSU (load data). Each source uses a

---
 rtl/regfile_wb_arbiter.sv | 122 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Purpose:
//   Shares the single register-file write port between the ALU and LSU
//   writeback sources. Each cycle at most one source is granted, chosen by
//   round-robin when both request at once. The winning request is registered
//   onto the regfile write port (wen_a/addr_a/in_a), so a write lands one
//   cycle after its handshake. The in-flight write is also bypassed onto the
//   read path so decode sees the value being written in the same cycle.
//
// Ports:
//   clk_a, rst_a           clock and synchronous active-high reset
//   hold                   freeze: no grant while high
//   alu_valid/ready/addr/data   ALU writeback request channel
//   lsu_valid/ready/addr/data   LSU writeback request channel
//   wen_a, addr_a, in_a    registered regfile write port
//   rd_addr, rf_rd_data    read address and raw regfile read data
//   rd_data                read data after write bypass
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic          clk_a,
    input  logic          rst_a,
    input  logic          hold,
    input  logic          alu_valid,
    output logic          alu_ready,
    input  logic [AW-1:0] alu_addr,
    input  logic [DW-1:0] alu_data,
    input  logic          lsu_valid,
    output logic          lsu_ready,
    input  logic [AW-1:0] lsu_addr,
    input  logic [DW-1:0] lsu_data,
    output logic          wen_a,
    output logic [AW-1:0] addr_a,
    output logic [DW-1:0] in_a,
    input  logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rf_rd_data,
    output logic [DW-1:0] rd_data
);

    // Which source wins a tie on the next contested cycle.
    typedef enum logic {
        PRIO_ALU = 1'b0,
        PRIO_LSU = 1'b1
    } prio_e;

    prio_e         prio_q, prio_d;
    logic          wen_q,  wen_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] in_q,   in_d;

    logic grant_alu;
    logic grant_lsu;
    logic can_grant;

    always_comb begin
        can_grant = !rst_a && !hold;
        grant_alu = 1'b0;
        grant_lsu = 1'b0;
        prio_d    = prio_q;
        wen_d     = 1'b0;
        addr_d    = addr_q;
        in_d      = in_q;

        if (can_grant) begin
            if (alu_valid && lsu_valid) begin
                grant_alu = (prio_q == PRIO_ALU);
                grant_lsu = (prio_q == PRIO_LSU);
            end else begin
                grant_alu = alu_valid;
                grant_lsu = lsu_valid;
            end
        end

        // A request to x0 is still consumed (and moves the priority), but it
        // never raises wen_a; address/data keep their last written values.
        if (grant_alu) begin
            prio_d = PRIO_LSU;
            if (alu_addr != '0) begin
                wen_d  = 1'b1;
                addr_d = alu_addr;
                in_d   = alu_data;
            end
        end else if (grant_lsu) begin
            prio_d = PRIO_ALU;
            if (lsu_addr != '0) begin
                wen_d  = 1'b1;
                addr_d = lsu_addr;
                in_d   = lsu_data;
            end
        end
    end

    always_ff @(posedge clk_a) begin
        if (rst_a) begin
            prio_q <= PRIO_ALU;
            wen_q  <= 1'b0;
            addr_q <= '0;
            in_q   <= '0;
        end else begin
            prio_q <= prio_d;
            wen_q  <= wen_d;
            addr_q <= addr_d;
            in_q   <= in_d;
        end
    end

    assign alu_ready = grant_alu;
    assign lsu_ready = grant_lsu;
    assign wen_a     = wen_q;
    assign addr_a    = addr_q;
    assign in_a      = in_q;

    // The regfile only commits at the end of the cycle in which wen_a is
    // high, so a read of that register must be forwarded from the write port.
    // x0 is excluded so it always reads as the regfile's hard zero.
    assign rd_data = (wen_q && (addr_q == rd_addr) && (rd_addr != '0)) ? in_q : rf_rd_data;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//
// Directed table of cycle vectors (hand-computed expectations), followed by
// randomized traffic checked against a behavioural model that tracks the
// tie-break turn, the pending write and a regfile image.
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

    logic        clk_a = 1'b0;
    logic        rst_a;
    logic        hold;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        lsu_valid, lsu_ready;
    logic [4:0]  lsu_addr;
    logic [31:0] lsu_data;
    logic        wen_a;
    logic [4:0]  addr_a;
    logic [31:0] in_a;
    logic [4:0]  rd_addr;
    logic [31:0] rf_rd_data;
    logic [31:0] rd_data;

    always #5 clk_a = ~clk_a;

    regfile_wb_arbiter #(.AW(5), .DW(32)) dut (
        .clk_a      (clk_a),
        .rst_a      (rst_a),
        .hold       (hold),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_addr   (alu_addr),
        .alu_data   (alu_data),
        .lsu_valid  (lsu_valid),
        .lsu_ready  (lsu_ready),
        .lsu_addr   (lsu_addr),
        .lsu_data   (lsu_data),
        .wen_a      (wen_a),
        .addr_a     (addr_a),
        .in_a       (in_a),
        .rd_addr    (rd_addr),
        .rf_rd_data (rf_rd_data),
        .rd_data    (rd_data)
    );

    typedef struct {
        logic        rst;
        logic        hold;
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        lv;
        logic [4:0]  la;
        logic [31:0] ld;
        logic [4:0]  ra;
        logic [31:0] rf;
        // expected combinational outputs during the cycle
        logic        ar;
        logic        lr;
        logic [31:0] rd;
        // expected registered outputs after the edge
        logic        wen;
        logic [4:0]  wa;
        logic [31:0] win;
    } vec_t;

    int vectors     = 0;
    int compares    = 0;
    int miscompares = 0;

    function automatic vec_t mk(
        input logic rst, input logic hold,
        input logic av, input logic [4:0] aa, input logic [31:0] ad,
        input logic lv, input logic [4:0] la, input logic [31:0] ld,
        input logic [4:0] ra, input logic [31:0] rf,
        input logic ar, input logic lr, input logic [31:0] rd,
        input logic wen, input logic [4:0] wa, input logic [31:0] win);
        vec_t v;
        v.rst = rst; v.hold = hold;
        v.av = av; v.aa = aa; v.ad = ad;
        v.lv = lv; v.la = la; v.ld = ld;
        v.ra = ra; v.rf = rf;
        v.ar = ar; v.lr = lr; v.rd = rd;
        v.wen = wen; v.wa = wa; v.win = win;
        return v;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        compares++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s (vector %0d): got %h, expected %h", name, idx, act, exp);
        end
    endtask

    // Drives one cycle of inputs, checks the combinational outputs mid-cycle,
    // then checks the registered write port just after the edge.
    task automatic apply(input vec_t v);
        int idx;
        idx        = vectors;
        vectors++;
        rst_a      = v.rst;
        hold       = v.hold;
        alu_valid  = v.av;
        alu_addr   = v.aa;
        alu_data   = v.ad;
        lsu_valid  = v.lv;
        lsu_addr   = v.la;
        lsu_data   = v.ld;
        rd_addr    = v.ra;
        rf_rd_data = v.rf;
        #2;
        chk("alu_ready", idx, {31'b0, alu_ready}, {31'b0, v.ar});
        chk("lsu_ready", idx, {31'b0, lsu_ready}, {31'b0, v.lr});
        chk("rd_data",   idx, rd_data, v.rd);
        @(posedge clk_a);
        #1;
        chk("wen_a",  idx, {31'b0, wen_a}, {31'b0, v.wen});
        chk("addr_a", idx, {27'b0, addr_a}, {27'b0, v.wa});
        chk("in_a",   idx, in_a, v.win);
        $display("vec %0d: rst=%0b hold=%0b av=%0b lv=%0b ra=%0d -> ar=%0b lr=%0b rd=%h | wen=%0b addr=%0d in=%h",
                 idx, v.rst, v.hold, v.av, v.lv, v.ra, alu_ready, lsu_ready, rd_data, wen_a, addr_a, in_a);
    endtask

    // ---------------- behavioural reference model ----------------
    // m_lsu_turn: LSU wins the next tie. m_wen/m_addr/m_in: write presented
    // to the regfile this cycle. mem: regfile contents as committed so far.
    logic        m_lsu_turn;
    logic        m_wen;
    logic [4:0]  m_addr;
    logic [31:0] m_in;
    logic [31:0] mem [32];

    task automatic model_step(inout vec_t v);
        int          winner;   // 0 none, 1 ALU, 2 LSU
        logic [4:0]  waddr;
        logic [31:0] wdata;
        winner = 0;
        if (!v.rst && !v.hold) begin
            if (v.av && v.lv)  winner = m_lsu_turn ? 2 : 1;
            else if (v.av)     winner = 1;
            else if (v.lv)     winner = 2;
        end
        v.rf = (v.ra == 5'd0) ? 32'd0 : mem[v.ra];
        v.ar = (winner == 1);
        v.lr = (winner == 2);
        v.rd = (m_wen && m_addr == v.ra && v.ra != 5'd0) ? m_in : v.rf;
        // regfile commits whatever is on the write port at this edge
        if (m_wen) mem[m_addr] = m_in;
        if (v.rst) begin
            m_lsu_turn = 1'b0;
            m_wen      = 1'b0;
            m_addr     = 5'd0;
            m_in       = 32'd0;
        end else if (winner != 0) begin
            waddr      = (winner == 1) ? v.aa : v.la;
            wdata      = (winner == 1) ? v.ad : v.ld;
            m_lsu_turn = (winner == 1);
            m_wen      = (waddr != 5'd0);
            if (waddr != 5'd0) begin
                m_addr = waddr;
                m_in   = wdata;
            end
        end else begin
            m_wen = 1'b0;
        end
        v.wen = m_wen;
        v.wa  = m_addr;
        v.win = m_in;
    endtask

    vec_t tbl[$];

    initial begin
        vec_t        v;
        logic        a_pend, l_pend;
        logic [4:0]  a_addr, l_addr;
        logic [31:0] a_data, l_data;

        rst_a = 1'b1; hold = 1'b0;
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_addr = '0; lsu_data = '0;
        rd_addr = '0; rf_rd_data = '0;

        //              rst hold av aa ad        lv la ld         ra rf         ar lr rd          wen wa win
        // reset
        tbl.push_back(mk(1,0, 0,0,0,         0,0,0,          0,0,          0,0,0,          0,0,0));
        // single ALU write, then bypass of it
        tbl.push_back(mk(0,0, 1,3,'h11,      0,0,0,          3,'h55,       1,0,'h55,       1,3,'h11));
        tbl.push_back(mk(0,0, 0,0,0,         0,0,0,          3,'h55,       0,0,'h11,       0,3,'h11));
        // reset with both requesting: no ready; then both from reset
        tbl.push_back(mk(1,0, 1,5,'hA,       1,6,'hB,        0,0,          0,0,0,          0,0,0));
        tbl.push_back(mk(0,0, 1,5,'hA,       1,6,'hB,        5,'h99,       1,0,'h99,       1,5,'hA));
        tbl.push_back(mk(0,0, 0,0,0,         1,6,'hB,        5,'h99,       0,1,'hA,        1,6,'hB));
        tbl.push_back(mk(0,0, 0,0,0,         0,0,0,          6,'h77,       0,0,'hB,        0,6,'hB));
        // both valid continuously: ALU,LSU,ALU,LSU,ALU,LSU
        tbl.push_back(mk(0,0, 1,1,'h101,     1,2,'h202,      0,0,          1,0,0,          1,1,'h101));
        tbl.push_back(mk(0,0, 1,3,'h103,     1,2,'h202,      0,0,          0,1,0,          1,2,'h202));
        tbl.push_back(mk(0,0, 1,3,'h103,     1,4,'h204,      0,0,          1,0,0,          1,3,'h103));
        tbl.push_back(mk(0,0, 1,5,'h105,     1,4,'h204,      0,0,          0,1,0,          1,4,'h204));
        tbl.push_back(mk(0,0, 1,5,'h105,     1,6,'h206,      0,0,          1,0,0,          1,5,'h105));
        tbl.push_back(mk(0,0, 1,7,'h107,     1,6,'h206,      0,0,          0,1,0,          1,6,'h206));
        tbl.push_back(mk(0,0, 1,7,'h107,     0,0,0,          0,0,          1,0,0,          1,7,'h107));
        // LSU x0 write: accepted, no wen, priority moves back to ALU
        tbl.push_back(mk(0,0, 1,8,'h808,     0,0,0,          0,0,          1,0,0,          1,8,'h808));
        tbl.push_back(mk(0,0, 0,0,0,         1,0,'hFF,       0,0,          0,1,0,          0,8,'h808));
        tbl.push_back(mk(0,0, 1,9,'h909,     1,10,'hAAA,     0,0,          1,0,0,          1,9,'h909));
        tbl.push_back(mk(0,0, 0,0,0,         1,10,'hAAA,     0,0,          0,1,0,          1,10,'hAAA));
        // hold for 3 cycles: nothing granted, priority (LSU) retained
        tbl.push_back(mk(0,0, 1,11,'hB0B,    0,0,0,          0,0,          1,0,0,          1,11,'hB0B));
        tbl.push_back(mk(0,1, 1,12,'hC0C,    1,13,'hD0D,     0,0,          0,0,0,          0,11,'hB0B));
        tbl.push_back(mk(0,1, 1,12,'hC0C,    1,13,'hD0D,     0,0,          0,0,0,          0,11,'hB0B));
        tbl.push_back(mk(0,1, 1,12,'hC0C,    1,13,'hD0D,     0,0,          0,0,0,          0,11,'hB0B));
        tbl.push_back(mk(0,0, 1,12,'hC0C,    1,13,'hD0D,     0,0,          0,1,0,          1,13,'hD0D));
        tbl.push_back(mk(0,0, 1,12,'hC0C,    0,0,0,          0,0,          1,0,0,          1,12,'hC0C));
        // bypass of r7, then non-matching read, then reset discards a request
        tbl.push_back(mk(0,0, 1,7,'h1234,    0,0,0,          7,'h5,        1,0,'h5,        1,7,'h1234));
        tbl.push_back(mk(0,0, 0,0,0,         0,0,0,          7,'h5,        0,0,'h1234,     0,7,'h1234));
        tbl.push_back(mk(0,0, 1,8,'h4321,    0,0,0,          0,0,          1,0,0,          1,8,'h4321));
        tbl.push_back(mk(1,0, 1,9,'h999,     0,0,0,          7,'h777,      0,0,'h777,      0,0,0));
        tbl.push_back(mk(0,0, 1,9,'h999,     1,4,'h444,      8,'h88,       1,0,'h88,       1,9,'h999));
        tbl.push_back(mk(0,0, 0,0,0,         1,4,'h444,      9,'h0,        0,1,'h999,      1,4,'h444));
        tbl.push_back(mk(0,0, 0,0,0,         0,0,0,          0,0,          0,0,0,          0,4,'h444));

        foreach (tbl[i]) apply(tbl[i]);

        // ---------------- randomized traffic vs model ----------------
        m_lsu_turn = 1'b0; m_wen = 1'b0; m_addr = 5'd4; m_in = 32'h444;
        for (int i = 0; i < 32; i++) mem[i] = 32'd0;
        a_pend = 1'b0; l_pend = 1'b0;
        a_addr = '0; l_addr = '0; a_data = '0; l_data = '0;

        for (int n = 0; n < 300; n++) begin
            if (!a_pend && $urandom_range(0, 1) == 1) begin
                a_pend = 1'b1;
                a_addr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                a_data = $urandom;
            end
            if (!l_pend && $urandom_range(0, 1) == 1) begin
                l_pend = 1'b1;
                l_addr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                l_data = $urandom;
            end
            v = mk((n == 0) || ($urandom_range(0, 49) == 0),
                   ($urandom_range(0, 5) == 0),
                   a_pend, a_addr, a_data,
                   l_pend, l_addr, l_data,
                   ($urandom_range(0, 1) == 1) ? m_addr : 5'($urandom_range(0, 31)), 0,
                   0, 0, 0, 0, 0, 0);
            model_step(v);
            apply(v);
            if (v.ar) a_pend = 1'b0;
            if (v.lr) l_pend = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
